// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle MIPS control FSM sharing one memory port via a ready handshake
module mips_multicycle_ctrl (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] state,
  output logic       pc_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic [1:0] pc_src,
  output logic       illegal
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, ADDIEX = 4'd9,
    ADDIWB = 4'd10, JUMP = 4'd11, TRAP = 4'd12
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  state_t state_q, state_d;
  logic [5:0] funct_q, funct_d;
  logic funct_ok;
  assign state = state_q;
  assign funct_ok = funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH;
      funct_q <= '0;
    end else begin
      state_q <= state_d;
      funct_q <= funct_d;
    end
  end
  always_comb begin
    state_d = state_q;
    funct_d = (state_q == DECODE) ? funct : funct_q;
    {pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
     alu_src_a, alu_src_b, alu_ctrl, pc_src, illegal} = '0;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_ctrl  = 3'b010;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        alu_ctrl  = 3'b010;
        state_d   = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                    (opcode == OP_R && funct_ok) ? EXEC :
                    (opcode == OP_BEQ) ? BRANCH :
                    (opcode == OP_ADDI) ? ADDIEX :
                    (opcode == OP_J) ? JUMP : TRAP;
      end
      MEMADR, ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = 3'b010;
        state_d   = (state_q == ADDIEX) ? ADDIWB : (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        state_d  = mem_ready ? MEMWB : MEMRD;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        state_d   = mem_ready ? FETCH : MEMWR;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = FETCH;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_ctrl  = (funct_q == 6'b100010) ? 3'b110 :
                    (funct_q == 6'b100100) ? 3'b000 :
                    (funct_q == 6'b100101) ? 3'b001 :
                    (funct_q == 6'b101010) ? 3'b111 : 3'b010;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = 3'b110;
        pc_src    = 2'b01;
        pc_write  = zero;
        state_d   = FETCH;
      end
      JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        state_d  = FETCH;
      end
      TRAP: begin
        illegal = 1'b1;
        state_d = TRAP;
      end
      default: state_d = FETCH;
    endcase
    if (reset) {pc_write, ir_write, reg_write, mem_read, mem_write} = '0;
  end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: randomized instruction streams checked against an instruction-level model
module tb_mips_multicycle_ctrl;
  logic clock = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic [3:0] state;
  logic pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic alu_src_a, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctrl;
  mips_multicycle_ctrl dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .state(state), .pc_write(pc_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .pc_src(pc_src), .illegal(illegal)
  );
  always #5 clock = ~clock;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  typedef struct packed {
    logic mr; logic z; logic [5:0] op; logic [5:0] fn; logic [3:0] st; logic [16:0] v;
  } ent_t;
  ent_t q[$];
  int n_cmp = 0, n_bad = 0;
  logic [16:0] obs;
  assign obs = {pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                alu_src_a, alu_src_b, alu_ctrl, pc_src, illegal};
  function automatic logic [16:0] mk(input bit pcw, io, mrd, mwr, irw, rdst, m2r, rw, asa,
                                     input logic [1:0] asb, input logic [2:0] ac,
                                     input logic [1:0] ps, input bit ill);
    return {pcw, io, mrd, mwr, irw, rdst, m2r, rw, asa, asb, ac, ps, ill};
  endfunction
  function automatic logic [2:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      default:   return 3'b111;
    endcase
  endfunction
  function automatic bit legal_fn(input logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction
  function automatic logic [5:0] r6();
    return 6'($urandom);
  endfunction
  function automatic logic rb();
    return 1'($urandom);
  endfunction
  task automatic push(input logic mr, z, input logic [5:0] op, fn, input logic [3:0] st,
                      input logic [16:0] v);
    q.push_back(ent_t'{mr, z, op, fn, st, v});
  endtask
  task automatic chk(input string tag, input logic [31:0] o, e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  // Expected cycle-by-cycle behaviour of one instruction; opcode/funct are random outside the
  // cycles where the controller may look at them.
  task automatic gen(input logic [5:0] op, fn, input int wf, wm, input logic z, output bit trapped);
    logic [16:0] mv;
    trapped = 1'b0;
    for (int i = 0; i < wf; i++) push(1'b0, rb(), r6(), r6(), 4'd0, mk(0,0,1,0,0,0,0,0,0,2'b01,3'b010,2'b00,0));
    push(1'b1, rb(), r6(), r6(), 4'd0, mk(1,0,1,0,1,0,0,0,0,2'b01,3'b010,2'b00,0));
    push(rb(), rb(), op, fn, 4'd1, mk(0,0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0));
    if (op == OP_LW || op == OP_SW) begin
      push(rb(), rb(), op, r6(), 4'd2, mk(0,0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0));
      mv = (op == OP_LW) ? mk(0,1,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0) : mk(0,1,0,1,0,0,0,0,0,2'b00,3'b000,2'b00,0);
      for (int i = 0; i < wm; i++) push(1'b0, rb(), r6(), r6(), (op == OP_LW) ? 4'd3 : 4'd5, mv);
      push(1'b1, rb(), r6(), r6(), (op == OP_LW) ? 4'd3 : 4'd5, mv);
      if (op == OP_LW) push(rb(), rb(), r6(), r6(), 4'd4, mk(0,0,0,0,0,0,1,1,0,2'b00,3'b000,2'b00,0));
    end else if (op == OP_R && legal_fn(fn)) begin
      push(rb(), rb(), r6(), r6(), 4'd6, mk(0,0,0,0,0,0,0,0,1,2'b00,alu_of(fn),2'b00,0));
      push(rb(), rb(), r6(), r6(), 4'd7, mk(0,0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00,0));
    end else if (op == OP_BEQ) begin
      push(rb(), z, r6(), r6(), 4'd8, mk(z,0,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,0));
    end else if (op == OP_ADDI) begin
      push(rb(), rb(), r6(), r6(), 4'd9, mk(0,0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0));
      push(rb(), rb(), r6(), r6(), 4'd10, mk(0,0,0,0,0,0,0,1,0,2'b00,3'b000,2'b00,0));
    end else if (op == OP_J) begin
      push(rb(), rb(), r6(), r6(), 4'd11, mk(1,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,0));
    end else begin
      trapped = 1'b1;
      for (int i = 0; i < 10 + int'($urandom_range(0, 3)); i++)
        push(rb(), rb(), r6(), r6(), 4'd12, mk(0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,1));
    end
  endtask
  task automatic run(input int limit);
    ent_t e;
    for (int k = 0; k < limit && q.size() > 0; k++) begin
      e = q.pop_front();
      mem_ready = e.mr; zero = e.z; opcode = e.op; funct = e.fn;
      @(negedge clock);
      chk("state", 32'(state), 32'(e.st));
      chk($sformatf("ctrl@st%0d", e.st), 32'(obs), 32'(e.v));
      @(posedge clock); #1;
    end
    q.delete();
  endtask
  task automatic do_reset();
    reset = 1'b1; mem_ready = 1'b1; opcode = r6(); funct = r6();
    @(negedge clock);
    chk("rst_enables", 32'({pc_write, ir_write, reg_write, mem_read, mem_write}), 32'd0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("rst_enables2", 32'({pc_write, ir_write, reg_write, mem_read, mem_write}), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
  endtask
  initial begin
    bit t;
    logic [5:0] ops [6] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [5:0] op, fn;
    @(posedge clock); #1;
    do_reset();
    gen(OP_LW, r6(), 0, 0, 1'b0, t); run(100);
    gen(OP_SW, r6(), 0, 2, 1'b0, t); run(100);
    gen(OP_R, 6'b100010, 0, 0, 1'b0, t); run(100);
    gen(OP_BEQ, r6(), 0, 0, 1'b1, t); run(100);
    gen(OP_BEQ, r6(), 1, 0, 1'b0, t); run(100);
    gen(OP_ADDI, r6(), 0, 0, 1'b0, t); run(100);
    gen(OP_J, r6(), 2, 0, 1'b0, t); run(100);
    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 9) == 0) ? r6() : ops[$urandom_range(0, 5)];
      fn = ($urandom_range(0, 7) == 0) ? r6() : fns[$urandom_range(0, 4)];
      gen(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), rb(), t);
      if ($urandom_range(0, 7) == 0) begin
        run($urandom_range(1, 4));
        do_reset();
      end else begin
        run(100);
        if (t) do_reset();
      end
    end
    gen(6'b111111, r6(), 0, 0, 1'b0, t); run(100);
    do_reset();
    gen(OP_LW, r6(), 1, 1, 1'b0, t); run(100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
